// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, legality check and the issue-buffer entry layout.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MIN = 4'b0011;

    localparam int ALU_DWIDTH = 32;
    localparam int ALU_AWIDTH = 5;

    // Default-width entry layout; modules with other widths declare a matching local struct.
    typedef struct packed {
        logic [3:0]            op;
        logic [ALU_AWIDTH-1:0] rs1_addr;
        logic [ALU_AWIDTH-1:0] rs2_addr;
        logic [ALU_DWIDTH-1:0] rs1;
        logic [ALU_DWIDTH-1:0] rs2;
        logic [ALU_AWIDTH-1:0] rd_addr;
    } alu_entry_t;

    // True for op codes the ALU actually implements.
    function automatic logic alu_op_legal(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
            ALU_NOR, ALU_SLT, ALU_MIN: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Per-operand forwarding select: replaces a stale operand with the write-back value
// when write-back targets the same non-zero register.
module alu_fwd_mux #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic [AWIDTH-1:0] i_addr,
    input  logic [DWIDTH-1:0] i_data,
    input  logic              i_wb_en,
    input  logic [AWIDTH-1:0] i_wb_addr,
    input  logic [DWIDTH-1:0] i_wb_data,
    output logic [DWIDTH-1:0] o_data
);

    logic w_hit;

    // Register 0 is hardwired, so a write-back to it must never be forwarded.
    assign w_hit  = i_wb_en && (i_wb_addr != '0) && (i_wb_addr == i_addr);
    assign o_data = w_hit ? i_wb_data : i_data;

endmodule

// File: rtl/alu_issue_buf.sv
// Execute-stage issue buffer: small FIFO of decoded ALU ops whose operands are kept
// fresh from the write-back bus, presenting the head entry to the combinational ALU.
module alu_issue_buf
    import alu_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [AWIDTH-1:0] in_rs1_addr,
    input  logic [AWIDTH-1:0] in_rs2_addr,
    input  logic [DWIDTH-1:0] in_rs1_data,
    input  logic [DWIDTH-1:0] in_rs2_data,
    input  logic [AWIDTH-1:0] in_rd_addr,
    input  logic              wb_en,
    input  logic [AWIDTH-1:0] wb_addr,
    input  logic [DWIDTH-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [DWIDTH-1:0] out_rs1,
    output logic [DWIDTH-1:0] out_rs2,
    output logic [AWIDTH-1:0] out_rd_addr,
    output logic              out_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [3:0]        op;
        logic [AWIDTH-1:0] rs1_addr;
        logic [AWIDTH-1:0] rs2_addr;
        logic [DWIDTH-1:0] rs1;
        logic [DWIDTH-1:0] rs2;
        logic [AWIDTH-1:0] rd_addr;
    } entry_t;

    entry_t            r_entry [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;

    logic              w_push;
    logic              w_pop;
    logic [DWIDTH-1:0] w_capRs1;
    logic [DWIDTH-1:0] w_capRs2;
    logic [DWIDTH-1:0] w_fwdRs1 [DEPTH];
    logic [DWIDTH-1:0] w_fwdRs2 [DEPTH];
    entry_t            w_head;

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_head    = r_entry[r_rdPtr];

    // Data outputs are forced to zero while empty so stale slots never leak out.
    assign out_op      = out_valid ? w_head.op      : '0;
    assign out_rs1     = out_valid ? w_head.rs1     : '0;
    assign out_rs2     = out_valid ? w_head.rs2     : '0;
    assign out_rd_addr = out_valid ? w_head.rd_addr : '0;
    assign out_illegal = out_valid && !alu_op_legal(w_head.op);

    alu_fwd_mux #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_capRs1 (
        .i_addr(in_rs1_addr), .i_data(in_rs1_data), .i_wb_en(wb_en),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_data(w_capRs1)
    );

    alu_fwd_mux #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_capRs2 (
        .i_addr(in_rs2_addr), .i_data(in_rs2_data), .i_wb_en(wb_en),
        .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_data(w_capRs2)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_storeFwd
        alu_fwd_mux #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_fwdRs1 (
            .i_addr(r_entry[g].rs1_addr), .i_data(r_entry[g].rs1), .i_wb_en(wb_en),
            .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_data(w_fwdRs1[g])
        );
        alu_fwd_mux #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_fwdRs2 (
            .i_addr(r_entry[g].rs2_addr), .i_data(r_entry[g].rs2), .i_wb_en(wb_en),
            .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_data(w_fwdRs2[g])
        );
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Entry storage: refresh buffered operands, retire the head, capture the new op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i]) begin
                    r_entry[i].rs1 <= w_fwdRs1[i];
                    r_entry[i].rs2 <= w_fwdRs2[i];
                end
            end
            if (w_pop) r_valid[r_rdPtr] <= 1'b0;
            if (w_push) begin
                r_entry[r_wrPtr] <= '{op: in_op, rs1_addr: in_rs1_addr, rs2_addr: in_rs2_addr,
                                      rs1: w_capRs1, rs2: w_capRs2, rd_addr: in_rd_addr};
                r_valid[r_wrPtr] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_buf.sv
// Self-checking bench for alu_issue_buf: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a queue-based model.
module tb_alu_issue_buf;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = '0;
    logic [AW-1:0] in_rs1_addr = '0;
    logic [AW-1:0] in_rs2_addr = '0;
    logic [DW-1:0] in_rs1_data = '0;
    logic [DW-1:0] in_rs2_data = '0;
    logic [AW-1:0] in_rd_addr = '0;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [3:0]    out_op;
    logic [DW-1:0] out_rs1;
    logic [DW-1:0] out_rs2;
    logic [AW-1:0] out_rd_addr;
    logic          out_illegal;

    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [AW-1:0] rd;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } mEntry_t;

    mEntry_t modelQ[$];
    int      testsRun = 0;
    int      testsFailed = 0;

    alu_issue_buf #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rd_addr(in_rd_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd_addr(out_rd_addr),
        .out_illegal(out_illegal)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                 input logic [AW-1:0] rd, input logic oReady);
        in_valid    = v;
        in_op       = op;
        in_rs1_addr = a1;
        in_rs2_addr = a2;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_rd_addr  = rd;
        out_ready   = oReady;
    endtask

    task automatic setWb(input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wb_en   = en;
        wb_addr = addr;
        wb_data = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fwdVal(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        if (wb_en && wb_addr != 0 && wb_addr == addr) return wb_data;
        return data;
    endfunction

    function automatic logic opLegal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'hC, 4'h7, 4'h3};
    endfunction

    // Reset throws away everything the model holds, immediately.
    always @(negedge rst_n) modelQ.delete();

    // Model: retire the head, refresh what remains from write-back, append the new op.
    always @(posedge clk) begin : modelStep
        bit      doPush;
        bit      doPop;
        mEntry_t e;
        if (rst_n) begin
            doPush = in_valid && (modelQ.size() < 2);
            doPop  = (modelQ.size() > 0) && out_ready;
            if (doPop) void'(modelQ.pop_front());
            foreach (modelQ[k]) begin
                modelQ[k].d1 = fwdVal(modelQ[k].a1, modelQ[k].d1);
                modelQ[k].d2 = fwdVal(modelQ[k].a2, modelQ[k].d2);
            end
            if (doPush) begin
                e.op = in_op;
                e.a1 = in_rs1_addr;
                e.a2 = in_rs2_addr;
                e.rd = in_rd_addr;
                e.d1 = fwdVal(in_rs1_addr, in_rs1_data);
                e.d2 = fwdVal(in_rs2_addr, in_rs2_data);
                modelQ.push_back(e);
            end
        end
    end

    // Every falling edge, compare all DUT outputs against the model's head.
    always @(negedge clk) begin : compare
        bit      has;
        mEntry_t h;
        has = modelQ.size() > 0;
        h   = '{op: '0, a1: '0, a2: '0, rd: '0, d1: '0, d2: '0};
        if (has) h = modelQ[0];
        checkOutput("cmp out_valid", 64'(out_valid), 64'(has));
        checkOutput("cmp in_ready", 64'(in_ready), 64'(modelQ.size() < 2));
        checkOutput("cmp out_op", 64'(out_op), 64'(h.op));
        checkOutput("cmp out_rs1", 64'(out_rs1), 64'(h.d1));
        checkOutput("cmp out_rs2", 64'(out_rs2), 64'(h.d2));
        checkOutput("cmp out_rd_addr", 64'(out_rd_addr), 64'(h.rd));
        checkOutput("cmp out_illegal", 64'(out_illegal), 64'(has && !opLegal(h.op)));
    end

    initial begin : stimulus
        logic [DW-1:0] nextVal;
        logic [DW-1:0] expHead;
        logic          accepted;

        // Reset state
        rst_n = 1'b0;
        repeat (2) tick();
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset out_rs1", 64'(out_rs1), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single ADD flows through with one-cycle latency
        applyStimulus(1'b1, 4'b0010, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3, 1'b1);
        tick();
        checkOutput("basic out_valid", 64'(out_valid), 64'd1);
        checkOutput("basic out_rs1", 64'(out_rs1), 64'd5);
        checkOutput("basic out_rs2", 64'(out_rs2), 64'd7);
        checkOutput("basic out_illegal", 64'(out_illegal), 64'd0);
        applyStimulus(1'b0, 4'b0000, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        tick();
        checkOutput("basic drained", 64'(out_valid), 64'd0);

        // Back-pressure: two fit, third is held by the source
        applyStimulus(1'b1, 4'b0000, 5'd1, 5'd2, 32'd100, 32'd0, 5'd1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b0001, 5'd1, 5'd2, 32'd101, 32'd0, 5'd2, 1'b0);
        tick();
        checkOutput("full in_ready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 4'b0110, 5'd1, 5'd2, 32'd102, 32'd0, 5'd3, 1'b0);
        tick();
        checkOutput("held in_ready", 64'(in_ready), 64'd0);
        checkOutput("held head", 64'(out_rs1), 64'd100);
        out_ready = 1'b1;
        tick();
        checkOutput("drain 2nd", 64'(out_rs1), 64'd101);
        tick();
        checkOutput("drain 3rd", 64'(out_rs1), 64'd102);
        in_valid = 1'b0;
        tick();
        checkOutput("drain empty", 64'(out_valid), 64'd0);

        // Forwarding at capture
        applyStimulus(1'b1, 4'b0010, 5'd4, 5'd6, 32'h11, 32'h22, 5'd1, 1'b0);
        setWb(1'b1, 5'd4, 32'hAA);
        tick();
        setWb(1'b0, 5'd0, 32'd0);
        checkOutput("capfwd out_rs1", 64'(out_rs1), 64'hAA);
        checkOutput("capfwd out_rs2", 64'(out_rs2), 64'h22);
        applyStimulus(1'b0, 4'b0000, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        tick();

        // Forwarding while buffered, and register 0 is never forwarded
        applyStimulus(1'b1, 4'b0010, 5'd0, 5'd9, 32'h22, 32'd1, 5'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        checkOutput("stall out_rs2", 64'(out_rs2), 64'd1);
        setWb(1'b1, 5'd0, 32'hFF);
        tick();
        checkOutput("wb0 out_rs1", 64'(out_rs1), 64'h22);
        checkOutput("wb0 out_rs2", 64'(out_rs2), 64'd1);
        setWb(1'b1, 5'd9, 32'h55);
        tick();
        setWb(1'b0, 5'd0, 32'd0);
        checkOutput("buffwd out_rs2", 64'(out_rs2), 64'h55);
        out_ready = 1'b1;
        tick();

        // Full buffer streaming across pointer wrap
        applyStimulus(1'b1, 4'b0010, 5'd1, 5'd2, 32'd200, 32'd0, 5'd3, 1'b0);
        tick();
        applyStimulus(1'b1, 4'b0010, 5'd1, 5'd2, 32'd201, 32'd0, 5'd3, 1'b0);
        tick();
        nextVal = 32'd202;
        expHead = 32'd200;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 4'b0010, 5'd1, 5'd2, nextVal, 32'd0, 5'd3, 1'b1);
            accepted = in_ready;
            tick();
            if (accepted) nextVal = nextVal + 1;
            expHead = expHead + 1;
            checkOutput("stream out_valid", 64'(out_valid), 64'd1);
            checkOutput("stream out_rs1", 64'(out_rs1), 64'(expHead));
        end
        applyStimulus(1'b0, 4'b0000, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        repeat (3) tick();

        // Illegal op is still buffered, flagged, and popped normally
        applyStimulus(1'b1, 4'b0101, 5'd1, 5'd2, 32'd3, 32'd4, 5'd5, 1'b0);
        tick();
        checkOutput("illegal flag", 64'(out_illegal), 64'd1);
        checkOutput("illegal valid", 64'(out_valid), 64'd1);
        applyStimulus(1'b0, 4'b0000, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        tick();
        checkOutput("illegal popped", 64'(out_valid), 64'd0);

        // Reset with two entries held clears immediately
        applyStimulus(1'b1, 4'b0000, 5'd1, 5'd2, 32'd7, 32'd8, 5'd1, 1'b0);
        tick();
        tick();
        in_valid = 1'b0;
        checkOutput("prereset in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset in_ready", 64'(in_ready), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic with narrow addresses to provoke forwarding hits
        for (int c = 0; c < 600; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                          $urandom, $urandom, AW'($urandom_range(0, 31)),
                          $urandom_range(0, 3) != 0);
            setWb(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom);
            tick();
        end
        applyStimulus(1'b0, 4'b0000, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b1);
        setWb(1'b0, 5'd0, 32'd0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/alu_issue_buf.md
Name: alu_issue_buf

Overview:
- Execute-stage issue buffer between decode/register-read and the combinational ALU.
- Accepts decoded ALU operations with a valid/ready handshake and holds up to 2 in a FIFO.
- Patches stale operands from the write-back bus, then presents the head entry to the ALU.
- Also flags op codes the ALU does not implement, so downstream can trap instead of consuming a silent zero result.

Parameters:
- DWIDTH, 32, operand/result width.
- AWIDTH, 5, register address width.
- DEPTH, 2, buffer entries (power of two, >=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode offers an operation.
- in_ready  out  1  buffer can accept this cycle.
- in_op  in  4  ALU op code.
- in_rs1_addr  in  AWIDTH  source 1 register index.
- in_rs2_addr  in  AWIDTH  source 2 register index.
- in_rs1_data  in  DWIDTH  source 1 value read at decode.
- in_rs2_data  in  DWIDTH  source 2 value read at decode.
- in_rd_addr  in  AWIDTH  destination register index.
- wb_en  in  1  write-back is writing this cycle.
- wb_addr  in  AWIDTH  write-back destination.
- wb_data  in  DWIDTH  write-back value.
- out_valid  out  1  head entry valid.
- out_ready  in  1  ALU/EX consumer takes head this cycle.
- out_op  out  4  head op to the ALU.
- out_rs1  out  DWIDTH  head operand 1.
- out_rs2  out  DWIDTH  head operand 2.
- out_rd_addr  out  AWIDTH  head destination.
- out_illegal  out  1  head op not in {0000,0001,0010,0110,1100,0111,0011}.

Behaviour:
- Reset (async, rst_n low): count=0, rd/wr pointers=0, every entry's valid bit=0, out_valid=0, in_ready=1. All out_* data driven 0 while the buffer is empty.
- Push when in_valid && in_ready. Pop when out_valid && out_ready. Nothing is lost or duplicated.
- in_ready = (count < DEPTH). It is a function of registered count only and never depends combinationally on out_ready.
- Latency: an entry pushed at edge N is visible at out_* after edge N, i.e. out_valid is high in cycle N+1. There is no combinational in->out path.
- out_* reflect the head entry; out_illegal is decoded from the head op.
- Simultaneous push+pop:
  - count unchanged; both pointers advance, wrapping modulo DEPTH.
  - When full, in_ready=0, so no push occurs even if a pop happens that cycle.
- Forwarding at capture: if wb_en && wb_addr!=0 && wb_addr==in_rsX_addr in the push cycle, the entry stores wb_data instead of in_rsX_data. rs1 and rs2 are checked independently, and both may match.
- Forwarding while buffered: every cycle, each valid entry whose rsX_addr matches wb_addr (under the same wb_en and non-zero conditions) overwrites its stored operand with wb_data at the edge. This includes the head while it is being popped; the popped value is the pre-edge value.
- Register 0 is never forwarded.
- Hold: out_* are stable while out_valid && !out_ready, except for a forwarding update of the stored operand.
- Illegal op: the entry is still buffered and presented with out_illegal=1. Its out_rs1/out_rs2 are still forwarded.
- Reset mid-operation: all entries discarded immediately; no partial pop.

Decomposition:
- Shared package alu_pkg:
  - 4-bit op constants ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_NOR=1100, ALU_SLT=0111, ALU_MIN=0011.
  - Function alu_op_legal(op).
  - Entry struct {op, rs1_addr, rs2_addr, rs1, rs2, rd_addr}.
- One natural sub-module: alu_fwd_mux, the per-operand compare-and-select (addr, data, wb_en, wb_addr, wb_data -> data). It is instantiated 2x at capture and 2xDEPTH for stored entries.

Test Plan:
- Reset, then push op=0010, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, out_rs1=5, out_rs2=7, out_illegal=0; following cycle out_valid=0.
- out_ready=0, push 3 ops back-to-back -> in_ready low after 2 pushes, 3rd held by source; set out_ready=1 -> outputs drained in push order, none lost.
- Push rs1_addr=4 with data 0x11 while wb_en=1, wb_addr=4, wb_data=0xAA -> out_rs1=0xAA.
- Buffer rs2_addr=9 (data 1) stalled with out_ready=0; one cycle later wb 9<=0x55 -> out_rs2 becomes 0x55 next cycle; wb to addr 0 has no effect.
- Full buffer with continuous push+pop for 10 cycles, incrementing rs1 -> throughput 1/cycle, order preserved across pointer wrap.
- Push op=0101 -> out_illegal=1, entry still popped normally; assert rst_n low with 2 entries held -> out_valid=0 and in_ready=1 immediately.
